// File: rtl/mac8_pkg.sv
// Shared constants and FSM state type for the MAC8 result path.
// Lane count is a power of two so the fill index fits in $clog2(LANES) bits.
package mac8_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned LANES  = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } gb_state_e;

endpackage

// File: rtl/gb_lane_reg.sv
// One gathering lane: a W-bit register with write-enable and synchronous clear.
// A write beats a clear in the same cycle, so the consumer can release the group and load lane 0 at once.
module gb_lane_reg #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (we_i) begin
            q_q <= d_i;
        end else if (clr_i) begin
            q_q <= '0;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gathering_buffer.sv
// Gathers (addr, data) words from a valid/ready stream into a LANES-wide bank with a valid mask.
// A held group accepts a new word in the same cycle it is released, so full-rate streams never stall.
module gathering_buffer #(
    parameter int unsigned DATA_W = mac8_pkg::DATA_W,
    parameter int unsigned ADDR_W = mac8_pkg::ADDR_W,
    parameter int unsigned LANES  = mac8_pkg::LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*DATA_W-1:0]      out_data,
    output logic [LANES*ADDR_W-1:0]      out_addr,
    output logic [LANES-1:0]             out_mask,
    output logic [$clog2(LANES):0]       fill_count
);

    import mac8_pkg::*;

    localparam int unsigned LW    = DATA_W + ADDR_W;
    localparam int unsigned IDX_W = $clog2(LANES);
    localparam int unsigned CNT_W = IDX_W + 1;

    gb_state_e          state_q;
    logic [CNT_W-1:0]   fill_count_q;
    logic [LANES-1:0]   mask_q;

    logic               accept;
    logic               release_grp;
    logic [IDX_W-1:0]   fill_idx;
    logic [LANES-1:0]   lane_we;
    logic [LW-1:0]      lane_q [LANES];

    assign in_ready    = (state_q == FULL) ? out_ready : 1'b1;
    assign accept      = in_valid && in_ready;
    assign release_grp = (state_q == FULL) && out_ready;
    assign fill_idx    = fill_count_q[IDX_W-1:0];

    // In FULL the only writable lane is 0: the word that starts the next group.
    always_comb begin
        lane_we = '0;
        if (accept) begin
            if (state_q == FULL) begin
                lane_we[0] = 1'b1;
            end else begin
                lane_we[fill_idx] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gb_lane_reg #(
            .W(LW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we_i  (lane_we[k]),
            .clr_i (release_grp),
            .d_i   ({in_addr, in_data}),
            .q_o   (lane_q[k])
        );

        assign out_data[k*DATA_W +: DATA_W] = lane_q[k][DATA_W-1:0];
        assign out_addr[k*ADDR_W +: ADDR_W] = lane_q[k][LW-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            fill_count_q <= '0;
            mask_q       <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        mask_q[fill_idx] <= 1'b1;
                        fill_count_q     <= fill_count_q + CNT_W'(1);
                    end
                    // A flush coinciding with an accept still closes the group, even from empty.
                    if ((accept && (fill_count_q == CNT_W'(LANES - 1) || flush)) ||
                        (flush && fill_count_q != '0)) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_q      <= FILL;
                        mask_q       <= in_valid ? LANES'(1) : '0;
                        fill_count_q <= in_valid ? CNT_W'(1) : '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_mask   = mask_q;
    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_gathering_buffer.sv
// Self-checking bench for gathering_buffer against a queue-based model of the current group.
module tb_gathering_buffer;

    localparam int DW = 19;
    localparam int AW = 6;
    localparam int L  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_addr = '0;
    logic [DW-1:0]   in_data = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [L*DW-1:0] out_data;
    logic [L*AW-1:0] out_addr;
    logic [L-1:0]    out_mask;
    logic [CW-1:0]   fill_count;

    int n_cmp = 0;
    int n_err = 0;

    word_t m_q[$];
    bit    m_full = 1'b0;
    bit    rdy_seen;
    bit    rdy_exp;

    always #5 clk = ~clk;

    gathering_buffer #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .LANES (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_mask  (out_mask),
        .fill_count(fill_count)
    );

    function automatic word_t m_lane(input int k);
        return (k < m_q.size()) ? m_q[k] : '0;
    endfunction

    function automatic logic [L-1:0] m_mask();
        logic [L-1:0] m = '0;
        for (int k = 0; k < m_q.size(); k++) m[k] = 1'b1;
        return m;
    endfunction

    // Drive one cycle, sample in_ready before the edge, advance the model, settle 1 ns past the edge.
    task automatic cyc(input bit r, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit fl, input bit ordy);
        word_t w;
        rst = r; in_valid = v; in_addr = a; in_data = d; flush = fl; out_ready = ordy;
        #3;
        rdy_seen = in_ready;
        rdy_exp  = !m_full || ordy;
        w.a = a; w.d = d;
        if (r) begin
            m_q.delete(); m_full = 1'b0;
        end else if (!m_full) begin
            if (v) m_q.push_back(w);
            if (m_q.size() == L || (fl && m_q.size() > 0)) m_full = 1'b1;
        end else if (ordy) begin
            m_q.delete(); m_full = 1'b0;
            if (v) m_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 1, 6'h3F, '1, 1, 1);
        cyc(1, 0, '0, '0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (fill_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", fill_count); end
        n_cmp++; if (out_mask !== '0) begin n_err++; $display("FAIL reset_mask got %h want 0", out_mask); end
        n_cmp++; if (out_data !== '0 || out_addr !== '0) begin
            n_err++; $display("FAIL reset_lanes got data %h addr %h want 0", out_data, out_addr);
        end
    endtask

    task automatic test_full_group();
        logic [DW-1:0] ed;
        cyc(1, 0, '0, '0, 0, 0);
        for (int k = 0; k < L; k++) begin
            cyc(0, 1, AW'(k), DW'(-(k + 1)), 0, 0);
            n_cmp++; if (out_valid !== (k == L - 1)) begin
                n_err++; $display("FAIL full_valid after word %0d got %b want %b", k, out_valid, k == L - 1);
            end
        end
        n_cmp++; if (out_mask !== 8'hFF) begin n_err++; $display("FAIL full_mask got %h want ff", out_mask); end
        for (int k = 0; k < L; k++) begin
            ed = DW'(-(k + 1));
            n_cmp++; if (out_data[k*DW +: DW] !== ed || out_addr[k*AW +: AW] !== AW'(k)) begin
                n_err++; $display("FAIL full_lane%0d got (%h,%0d) want (%h,%0d)", k,
                                  out_data[k*DW +: DW], out_addr[k*AW +: AW], ed, k);
            end
        end
    endtask

    task automatic test_backpressure();
        word_t w;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, AW'($urandom), DW'($urandom), 0, 0);
            n_cmp++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL bp_ready cycle %0d got %b want 0", i, rdy_seen); end
            n_cmp++; if (out_valid !== 1'b1 || out_mask !== 8'hFF) begin
                n_err++; $display("FAIL bp_hold cycle %0d got valid %b mask %h want 1 ff", i, out_valid, out_mask);
            end
            for (int k = 0; k < L; k++) begin
                w = m_lane(k);
                n_cmp++; if (out_data[k*DW +: DW] !== w.d || out_addr[k*AW +: AW] !== w.a) begin
                    n_err++; $display("FAIL bp_lane%0d got (%h,%h) want (%h,%h)", k,
                                      out_data[k*DW +: DW], out_addr[k*AW +: AW], w.d, w.a);
                end
            end
        end
        cyc(0, 1, AW'(9), DW'(42), 0, 1);
        n_cmp++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL bp_pass_ready got %b want 1", rdy_seen); end
        n_cmp++; if (out_valid !== 1'b0 || fill_count !== CW'(1) || out_mask !== 8'h01) begin
            n_err++; $display("FAIL bp_restart got valid %b count %0d mask %h want 0 1 01", out_valid, fill_count, out_mask);
        end
        n_cmp++; if (out_data[DW-1:0] !== DW'(42) || out_addr[AW-1:0] !== AW'(9) ||
                     out_data[L*DW-1:DW] !== '0 || out_addr[L*AW-1:AW] !== '0) begin
            n_err++; $display("FAIL bp_lane0 got data %h addr %h want lane0 (42,9) rest 0", out_data, out_addr);
        end
    endtask

    task automatic test_flush();
        word_t w;
        cyc(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, AW'($urandom), DW'($urandom), 0, 0);
        cyc(0, 0, '0, '0, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_mask !== 8'h07 || fill_count !== CW'(3)) begin
            n_err++; $display("FAIL flush_group got valid %b mask %h count %0d want 1 07 3", out_valid, out_mask, fill_count);
        end
        for (int k = 0; k < L; k++) begin
            w = m_lane(k);
            n_cmp++; if (out_data[k*DW +: DW] !== w.d || out_addr[k*AW +: AW] !== w.a) begin
                n_err++; $display("FAIL flush_lane%0d got (%h,%h) want (%h,%h)", k,
                                  out_data[k*DW +: DW], out_addr[k*AW +: AW], w.d, w.a);
            end
        end
        cyc(0, 0, '0, '0, 0, 1);
        cyc(0, 0, '0, '0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || out_mask !== '0 || fill_count !== '0) begin
            n_err++; $display("FAIL flush_empty got valid %b mask %h count %0d want 0 00 0", out_valid, out_mask, fill_count);
        end
    endtask

    task automatic test_flush_same_cycle();
        logic [DW-1:0] d3;
        logic [AW-1:0] a3;
        d3 = DW'($urandom); a3 = AW'($urandom);
        cyc(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, AW'($urandom), DW'($urandom), 0, 0);
        cyc(0, 1, a3, d3, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_mask !== 8'h07) begin
            n_err++; $display("FAIL flush_same got valid %b mask %h want 1 07", out_valid, out_mask);
        end
        n_cmp++; if (out_data[2*DW +: DW] !== d3 || out_addr[2*AW +: AW] !== a3) begin
            n_err++; $display("FAIL flush_same_lane2 got (%h,%h) want (%h,%h)",
                              out_data[2*DW +: DW], out_addr[2*AW +: AW], d3, a3);
        end
        cyc(0, 0, '0, '0, 0, 1);
    endtask

    task automatic test_stream();
        word_t sent[$];
        word_t recv[$];
        word_t w;
        int drops = 0;
        int groups = 0;
        cyc(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            w.a = AW'($urandom);
            w.d = (i == 5) ? DW'(-262144) : (i == 20) ? DW'(262143) : DW'($urandom);
            sent.push_back(w);
        end
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) cyc(0, 1, sent[i].a, sent[i].d, 0, 1);
            else        cyc(0, 0, '0, '0, 0, 1);
            if (i < 32 && rdy_seen !== 1'b1) drops++;
            if (out_valid === 1'b1) begin
                groups++;
                for (int k = 0; k < L; k++) begin
                    if (out_mask[k]) begin
                        w.d = out_data[k*DW +: DW]; w.a = out_addr[k*AW +: AW];
                        recv.push_back(w);
                    end
                end
            end
        end
        n_cmp++; if (drops != 0) begin n_err++; $display("FAIL stream_drops got %0d want 0", drops); end
        n_cmp++; if (groups != 4) begin n_err++; $display("FAIL stream_groups got %0d want 4", groups); end
        n_cmp++; if (recv.size() != 32) begin n_err++; $display("FAIL stream_words got %0d want 32", recv.size()); end
        for (int i = 0; i < 32 && i < recv.size(); i++) begin
            n_cmp++; if (recv[i] !== sent[i]) begin
                n_err++; $display("FAIL stream_word%0d got %h want %h", i, recv[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        word_t w;
        cyc(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, AW'($urandom), DW'($urandom), 0, 0);
        cyc(1, 1, AW'($urandom), DW'($urandom), 1, 1);
        n_cmp++; if (out_valid !== 1'b0 || fill_count !== '0 || out_mask !== '0) begin
            n_err++; $display("FAIL rstmid_state got valid %b count %0d mask %h want 0 0 00", out_valid, fill_count, out_mask);
        end
        for (int i = 0; i < L; i++) cyc(0, 1, AW'($urandom), DW'($urandom), 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_mask !== 8'hFF) begin
            n_err++; $display("FAIL rstmid_group got valid %b mask %h want 1 ff", out_valid, out_mask);
        end
        for (int k = 0; k < L; k++) begin
            w = m_lane(k);
            n_cmp++; if (out_data[k*DW +: DW] !== w.d || out_addr[k*AW +: AW] !== w.a) begin
                n_err++; $display("FAIL rstmid_lane%0d got (%h,%h) want (%h,%h)", k,
                                  out_data[k*DW +: DW], out_addr[k*AW +: AW], w.d, w.a);
            end
        end
    endtask

    task automatic test_random();
        word_t w;
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
            n_cmp++; if (!rst && rdy_seen !== rdy_exp) begin
                n_err++; $display("FAIL rand_ready cycle %0d got %b want %b", i, rdy_seen, rdy_exp);
            end
            n_cmp++; if (out_valid !== m_full || out_mask !== m_mask() || fill_count !== CW'(m_q.size())) begin
                n_err++; $display("FAIL rand_ctrl cycle %0d got valid %b mask %h count %0d want %b %h %0d",
                                  i, out_valid, out_mask, fill_count, m_full, m_mask(), m_q.size());
            end
            for (int k = 0; k < L; k++) begin
                w = m_lane(k);
                n_cmp++; if (out_data[k*DW +: DW] !== w.d || out_addr[k*AW +: AW] !== w.a) begin
                    n_err++; $display("FAIL rand_lane%0d cycle %0d got (%h,%h) want (%h,%h)", k, i,
                                      out_data[k*DW +: DW], out_addr[k*AW +: AW], w.d, w.a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_backpressure();
        test_flush();
        test_flush_same_cycle();
        test_stream();
        test_reset_mid_group();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
